// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/ready handshake between the pipeline sequencer and the
// data memory.
//   dmem_req   : sequencer -> memory, an access is presented this cycle
//   dmem_ready : memory -> sequencer, the current access completes this cycle
interface pipe_hazard_ctrl_if;
    logic dmem_req;
    logic dmem_ready;

    modport master (output dmem_req, input dmem_ready);
    modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core. It generates the
// enable/flush controls for the PC and every pipeline register, and the
// PC-source select. It handles load-use stalls, MEM-stage redirects and
// multi-cycle data-memory accesses, and it provides a dmem wait-timeout error
// and stall/flush performance counters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt   source operands of the instruction in ID
//   ex_rt, ex_MemRead          destination and load flag of the instruction in EX
//   mem_MemRead, mem_MemWrite  MEM-stage memory access
//   mem_branch_taken, mem_Jump MEM-stage control transfer
//   dmem                       dmem_req/dmem_ready handshake (master side)
//   pc_en, pc_src              PC enable and source (00 PC+4, 01 branch, 10 jump)
//   *_en, *_flush              pipeline register load enables and clears
//   memwb_bubble               load MEM/WB with zero controls
//   mem_err                    sticky dmem timeout error
//   stall_cnt, flush_cnt       performance counters (wrapping)
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_MemRead,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             mem_branch_taken,
    input  logic             mem_Jump,
    pipe_hazard_ctrl_if.master dmem,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_d;
    logic           mem_op, mem_stall, load_use, redirect, in_err;
    logic           req, stall_inc, flush_inc;

    assign dmem.dmem_req = req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err    <= mem_err_d;
            if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mem_op    = mem_MemRead | mem_MemWrite;
        in_err    = (state_q == S_ERR);
        mem_stall = (mem_op & ~dmem.dmem_ready) | in_err;
        redirect  = mem_branch_taken | mem_Jump;
        load_use  = ex_MemRead && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

        // Counters only advance out of reset; the register block enforces it.
        stall_inc = mem_stall | (load_use & ~redirect);
        flush_inc = redirect & ~mem_stall;

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !dmem.dmem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            S_WAIT: begin
                if (dmem.dmem_ready) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d   = S_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_ERR:   ;
            default: state_d = S_IDLE;
        endcase

        req          = 1'b0;
        pc_en        = 1'b0;
        pc_src       = 2'b00;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        exmem_flush  = 1'b0;
        memwb_en     = 1'b0;
        memwb_bubble = 1'b0;

        // Outputs are gated by rst_n so that an asserted reset drops every
        // control (including dmem_req) without waiting for a clock edge.
        if (rst_n) begin
            req = mem_op & ~in_err;
            if (mem_stall) begin
                // Frozen front end; MEM/WB keeps draining with a bubble.
                memwb_en     = 1'b1;
                memwb_bubble = 1'b1;
            end else if (redirect) begin
                pc_en       = 1'b1;
                pc_src      = mem_Jump ? 2'b10 : 2'b01;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                idex_flush  = 1'b1;
                exmem_en    = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MAX_WAIT overridden to 4).
// Control outputs are packed as
// {dmem_req, pc_en, pc_src[1:0], ifid_en, ifid_flush, idex_en, idex_flush,
//  exmem_en, exmem_flush, memwb_en, memwb_bubble}.
module tb_pipe_hazard_ctrl;

    localparam logic [11:0] C_RST   = 12'b0000_0000_0000;
    localparam logic [11:0] C_NORM  = 12'b0100_1010_1010;
    localparam logic [11:0] C_REQN  = 12'b1100_1010_1010;
    localparam logic [11:0] C_LU    = 12'b0000_0011_1010;
    localparam logic [11:0] C_STREQ = 12'b1000_0000_0011;
    localparam logic [11:0] C_ERR   = 12'b0000_0000_0011;
    localparam logic [11:0] C_BR    = 12'b0101_1111_1110;
    localparam logic [11:0] C_JMP   = 12'b0110_1111_1110;
    localparam logic [11:0] C_REQBR = 12'b1101_1111_1110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_MemRead = 1'b0;
    logic        mem_MemRead = 1'b0, mem_MemWrite = 1'b0;
    logic        mem_branch_taken = 1'b0, mem_Jump = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_bubble, mem_err;
    logic [1:0]  pc_src;
    logic [31:0] stall_cnt, flush_cnt;
    logic [11:0] ctrl;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_MemRead(ex_MemRead),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_branch_taken(mem_branch_taken), .mem_Jump(mem_Jump),
        .dmem(bus.master),
        .pc_en(pc_en), .pc_src(pc_src),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_bubble(memwb_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl = {bus.dmem_req, pc_en, pc_src, ifid_en, ifid_flush, idex_en,
                   idex_flush, exmem_en, exmem_flush, memwb_en, memwb_bubble};

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rt = '0; ex_MemRead = 1'b0;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
        mem_branch_taken = 1'b0; mem_Jump = 1'b0; bus.dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_RST) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RST); end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b expected 0 0 0", stall_cnt, flush_cnt, mem_err);
        end
        next_cycle();
        rst_n = 1'b1;
        exp_stall = 0; exp_flush = 0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORM) begin errors++; $display("FAIL reset_release: got %b expected %b", ctrl, C_NORM); end
        next_cycle();
    endtask

    task automatic test_load_use();
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        @(negedge clk);
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("FAIL lu_rs: got %b expected %b", ctrl, C_LU); end
        next_cycle();
        exp_stall++;
        ex_MemRead = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORM) begin errors++; $display("FAIL lu_after: got %b expected %b", ctrl, C_NORM); end
        checks++;
        if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        next_cycle();
        // Load into $0 never creates a hazard.
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORM) begin errors++; $display("FAIL lu_r0: got %b expected %b", ctrl, C_NORM); end
        next_cycle();
        // rt match only counts when the ID instruction reads rt.
        ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_LU) begin errors++; $display("FAIL lu_rt: got %b expected %b", ctrl, C_LU); end
        next_cycle();
        exp_stall++;
        id_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORM) begin errors++; $display("FAIL lu_rt_unused: got %b expected %b", ctrl, C_NORM); end
        checks++;
        if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt2: got %0d expected %0d", stall_cnt, exp_stall); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        mem_MemRead = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== C_STREQ) begin errors++; $display("FAIL wait_stall[%0d]: got %b expected %b", i, ctrl, C_STREQ); end
            next_cycle();
            exp_stall++;
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REQN) begin errors++; $display("FAIL wait_done: got %b expected %b", ctrl, C_REQN); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'(exp_stall) || mem_err !== 1'b0) begin
            errors++; $display("FAIL wait_cnt: got stall=%0d err=%b expected %0d 0", stall_cnt, mem_err, exp_stall);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        // Op N: one wait cycle then ready.
        mem_MemWrite = 1'b1; bus.dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_STREQ) begin errors++; $display("FAIL b2b_op1_wait: got %b expected %b", ctrl, C_STREQ); end
        next_cycle();
        exp_stall++;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REQN) begin errors++; $display("FAIL b2b_op1_done: got %b expected %b", ctrl, C_REQN); end
        next_cycle();
        // Op N+1 issued from IDLE: zero-wait.
        mem_MemWrite = 1'b0; mem_MemRead = 1'b1; bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REQN) begin errors++; $display("FAIL b2b_op2: got %b expected %b", ctrl, C_REQN); end
        next_cycle();
        // Op N+2 waits again, proving the FSM is back in IDLE.
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_STREQ) begin errors++; $display("FAIL b2b_op3_wait: got %b expected %b", ctrl, C_STREQ); end
        next_cycle();
        exp_stall++;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REQN) begin errors++; $display("FAIL b2b_op3_done: got %b expected %b", ctrl, C_REQN); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_redirect();
        mem_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_BR) begin errors++; $display("FAIL br: got %b expected %b", ctrl, C_BR); end
        next_cycle();
        exp_flush++;
        mem_Jump = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_JMP) begin errors++; $display("FAIL br_and_jump: got %b expected %b", ctrl, C_JMP); end
        checks++;
        if (flush_cnt !== 32'(exp_flush)) begin errors++; $display("FAIL flush_cnt1: got %0d expected %0d", flush_cnt, exp_flush); end
        next_cycle();
        exp_flush++;
        mem_branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_JMP) begin errors++; $display("FAIL jump: got %b expected %b", ctrl, C_JMP); end
        next_cycle();
        exp_flush++;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (flush_cnt !== 32'(exp_flush)) begin errors++; $display("FAIL flush_cnt3: got %0d expected %0d", flush_cnt, exp_flush); end
        next_cycle();
    endtask

    task automatic test_priority();
        // Redirect beats load-use; no stall is counted.
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; mem_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_BR) begin errors++; $display("FAIL prio_br_lu: got %b expected %b", ctrl, C_BR); end
        next_cycle();
        exp_flush++;
        ex_MemRead = 1'b0;
        // Memory stall masks the redirect until the access completes.
        mem_MemRead = 1'b1; bus.dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_STREQ) begin errors++; $display("FAIL prio_stall_br: got %b expected %b", ctrl, C_STREQ); end
        checks++;
        if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
            errors++; $display("FAIL prio_cnt: got stall=%0d flush=%0d expected %0d %0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
        next_cycle();
        exp_stall++;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REQBR) begin errors++; $display("FAIL prio_ready_br: got %b expected %b", ctrl, C_REQBR); end
        next_cycle();
        exp_flush++;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
            errors++; $display("FAIL prio_cnt2: got stall=%0d flush=%0d expected %0d %0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        mem_MemWrite = 1'b1; bus.dmem_ready = 1'b0;
        // IDLE cycle plus four WAIT cycles (wait_cnt 1..4) before ERR.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== C_STREQ || mem_err !== 1'b0) begin
                errors++; $display("FAIL to_wait[%0d]: got %b err=%b expected %b err=0", i, ctrl, mem_err, C_STREQ);
            end
            next_cycle();
            exp_stall++;
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                mem_MemWrite = 1'b0; bus.dmem_ready = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (ctrl !== C_ERR || mem_err !== 1'b1) begin
                errors++; $display("FAIL to_err[%0d]: got %b err=%b expected %b err=1", i, ctrl, mem_err, C_ERR);
            end
            next_cycle();
            exp_stall++;
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL to_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_stall = 0; exp_flush = 0;
        next_cycle();
        mem_MemRead = 1'b1; bus.dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl !== C_STREQ || mem_err !== 1'b0) begin
            errors++; $display("FAIL rmw_start: got %b err=%b expected %b err=0", ctrl, mem_err, C_STREQ);
        end
        next_cycle();
        next_cycle();
        // Second WAIT cycle: reset mid-cycle, mem op still presented.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_RST) begin errors++; $display("FAIL rmw_ctrl: got %b expected %b", ctrl, C_RST); end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL rmw_regs: got stall=%0d flush=%0d err=%b expected 0 0 0", stall_cnt, flush_cnt, mem_err);
        end
        next_cycle();
        rst_n = 1'b1; bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== C_REQN) begin errors++; $display("FAIL rmw_zero_wait: got %b expected %b", ctrl, C_REQN); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (ctrl !== C_NORM || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rmw_after: got %b stall=%0d expected %b 0", ctrl, stall_cnt, C_NORM);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_back_to_back();
        test_redirect();
        test_priority();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
